tetris_cmd_queue: RTL
=====================

Name: tetris_cmd_queue

Overview:
- Sits directly downstream of the per-button debounce stage, which emits one-cycle pulses for left, right, rotate and drop.
- Converts those pulses into 2-bit move commands.
- Serialises simultaneous presses by fixed priority.
- Buffers the commands in a small FIFO for the game-logic FSM, which consumes them with a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the saturating dropped-press counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_left  in  1  one-cycle press pulse from the debounce stage.
- btn_right  in  1  one-cycle press pulse.
- btn_rot  in  1  one-cycle press pulse.
- btn_drop  in  1  one-cycle press pulse.
- flush  in  1  synchronous clear of pending presses and FIFO (new piece / game over).
- cmd_ready  in  1  consumer accepts the head command this cycle.
- cmd_valid  out  1  FIFO non-empty.
- cmd_code  out  2  head command: LEFT=0, RIGHT=1, ROT=2, DROP=3.
- fifo_count  out  $clog2(DEPTH)+1  number of stored commands.
- overflow  out  1  sticky; set when any press is dropped.
- drop_cnt  out  CNT_W  saturating count of dropped presses.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - On a clk edge with reset=1, all outputs, pending bits and FIFO pointers go to 0; cmd_code reads 0.
  - Reset has priority over flush and over every other input.
- Pending register: 4 bits, one per button.
  - A pulse sampled at edge k sets its bit at edge k.
- Transfer:
  - At each edge where pending != 0 and the FIFO can accept, the highest-priority pending bit is pushed and cleared.
  - Priority: DROP > ROT > LEFT > RIGHT.
  - Exactly one transfer per cycle. Four simultaneous presses therefore enter the FIFO over 4 consecutive edges in the order DROP, ROT, LEFT, RIGHT.
- Can-accept: fifo_count < DEPTH, or fifo_count == DEPTH with a pop in the same cycle (simultaneous push and pop at full is legal).
- Latency:
  - Press sampled at edge k, FIFO empty, no other pending: pushed at edge k+1.
  - cmd_valid is high in the cycle after edge k+1.
- Set/clear collision: a new pulse for a button whose bit is being transferred this cycle leaves the bit set. The new press becomes pending and is not counted as dropped.
- Coalescing: a pulse for a button whose bit is already set and not being transferred this cycle is discarded. Effects:
  - overflow <= 1.
  - drop_cnt increments by 1 per discarded pulse, saturating at 2^CNT_W-1. If two buttons are discarded in the same cycle, add 2, still saturating.
- FIFO full: pending bits simply wait; no loss unless coalescing occurs.
- Pop: happens when cmd_valid && cmd_ready.
  - cmd_ready while empty is ignored; no pointer change.
  - cmd_code is the registered head and updates on the edge after a pop.
- fifo_count = pushes - pops. Pointers wrap modulo DEPTH.
- Flush:
  - At the edge, pending <= 0, FIFO emptied and count <= 0.
  - Pulses sampled in the flush cycle are discarded without counting.
  - A pop requested in the flush cycle has no additional effect.
  - overflow and drop_cnt are NOT cleared by flush; only reset clears them.
- Invariants: cmd_valid == (fifo_count != 0); fifo_count <= DEPTH always.

Decomposition:
- tetris_pkg holds the command-code localparams (CMD_LEFT, CMD_RIGHT, CMD_ROT, CMD_DROP) and the command width (2). The game FSM imports the same package.
- One sub-module: cmd_fifo.
  - Synchronous DEPTH x 2 FIFO with push, pop, flush, full, empty and count.
  - Instantiated once.
- Priority encoder, pending register and drop counter live in tetris_cmd_queue.

Test Plan:
- Reset, then a single btn_left pulse at edge 5, cmd_ready=0 -> cmd_valid=1, cmd_code=0, fifo_count=1 after edge 6; overflow=0.
- All four pulses in one cycle, cmd_ready=1 held -> codes delivered in order 3, 2, 0, 1 on 4 consecutive cycles; fifo_count never exceeds 1; drop_cnt=0.
- cmd_ready=0; press 5 distinct-cycle presses across buttons (DEPTH=4) -> fifo_count=4, the fifth remains pending. Then pulse that same button again -> overflow=1, drop_cnt=1. Then release cmd_ready -> 5 commands emerge, not 6.
- FIFO full plus a pending press, with cmd_ready=1 for one cycle -> a pop and a push happen at the same edge; fifo_count stays 4; the new tail equals the pending code.
- Repeat the coalescing drop 300 times with CNT_W=8 -> drop_cnt saturates at 255. Then flush -> fifo_count=0, cmd_valid=0, drop_cnt stays 255, overflow stays 1. Then reset -> all 0.
- Assert btn_drop and flush in the same cycle while 2 entries are stored -> after the edge, empty, pending=0, no later DROP command, drop_cnt unchanged.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared command encoding for the input queue and the game-logic FSM.
package tetris_pkg;

  localparam int CMD_W = 2;

  localparam logic [CMD_W-1:0] CMD_LEFT  = 2'd0;
  localparam logic [CMD_W-1:0] CMD_RIGHT = 2'd1;
  localparam logic [CMD_W-1:0] CMD_ROT   = 2'd2;
  localparam logic [CMD_W-1:0] CMD_DROP  = 2'd3;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous command FIFO with a registered head word.
// The head register always holds the entry at the read pointer, so the
// consumer sees the next command on the edge after a pop.
module cmd_fifo
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [CMD_W-1:0]         push_data,
  input  logic                     pop,
  output logic [CMD_W-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    remain;
  logic             pop_eff;
  logic             push_eff;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_eff  = pop & ~empty;
  // Push at full is legal only when the same edge frees a slot.
  assign push_eff = push & (~full | pop_eff);
  assign rd_next  = rd_ptr + AW'(pop_eff);
  assign remain   = count - CW'(pop_eff);

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (push_eff && !flush && !reset) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_eff);
      rd_ptr <= rd_next;
      count  <= count + CW'(push_eff) - CW'(pop_eff);
      if (remain == '0) begin
        // Nothing left behind the pop: the incoming word becomes head.
        if (push_eff) begin
          head <= push_data;
        end
      end else begin
        head <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/tetris_cmd_queue.sv
// Button-pulse to move-command queue: latches debounced presses into a
// pending register, serialises them by fixed priority (DROP > ROT > LEFT >
// RIGHT) and buffers them for the game FSM behind a valid/ready handshake.
module tetris_cmd_queue
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_rot,
  input  logic                   btn_drop,
  input  logic                   flush,
  input  logic                   cmd_ready,
  output logic                   cmd_valid,
  output logic [CMD_W-1:0]       cmd_code,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);

  // Pending bits are indexed by command code.
  logic [3:0]       btn_vec;
  logic [3:0]       pending;
  logic [3:0]       sel;
  logic [3:0]       xfer_sel;
  logic [3:0]       dropped;
  logic [CMD_W-1:0] push_code;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign btn_vec = {btn_drop, btn_rot, btn_right, btn_left};

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [2:0]       inc);
    logic [CNT_W+3:0] sum;
    sum = (CNT_W + 4)'(a) + (CNT_W + 4)'(inc);
    if (sum > (CNT_W + 4)'({CNT_W{1'b1}})) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  // Fixed-priority pick of the next pending press.
  always_comb begin
    sel       = '0;
    push_code = CMD_LEFT;
    if (pending[CMD_DROP]) begin
      sel[CMD_DROP] = 1'b1;
      push_code     = CMD_DROP;
    end else if (pending[CMD_ROT]) begin
      sel[CMD_ROT] = 1'b1;
      push_code    = CMD_ROT;
    end else if (pending[CMD_LEFT]) begin
      sel[CMD_LEFT] = 1'b1;
      push_code     = CMD_LEFT;
    end else if (pending[CMD_RIGHT]) begin
      sel[CMD_RIGHT] = 1'b1;
      push_code      = CMD_RIGHT;
    end
  end

  assign pop      = cmd_valid & cmd_ready;
  assign push     = (pending != '0) && (!fifo_full || pop) && !flush;
  assign xfer_sel = sel & {4{push}};
  // A repeat press on a bit leaving this cycle is kept, not dropped.
  assign dropped  = btn_vec & pending & ~xfer_sel;

  // Pending register and dropped-press bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (flush) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~xfer_sel) | btn_vec;
      if (dropped != '0) begin
        overflow <= 1'b1;
        drop_cnt <= sat_add(drop_cnt, popcount4(dropped));
      end
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_code),
    .pop       (pop),
    .head      (cmd_code),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd_valid = ~fifo_empty;

endmodule
